pic_int_cond: RTL and testbench

- Input conditioner that sits directly upstream of the PIC16 core's INT pin.
- Takes N raw board inputs (push-buttons, switches, external strobes) asynchronous to PICCLK.
- Per channel: synchronises, debounces, edge-detects, and latches a pending flag; drives a single registered INT plus debounced levels that firmware reads back through RA/RB.
- Runs in the PICCLK domain; reset comes from the same PLL-lock-derived reset as the core.

---
 rtl/pic_pkg.sv | 31 +++
 rtl/pic_debounce.sv | 51 +++++
 rtl/pic_int_cond.sv | 81 ++++++++
 tb/tb_pic_int_cond.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC16 interrupt input conditioner.
//   DEB_10MS_70M : debounce length for 10 ms at a 70 MHz PICCLK
//   DEB_SIM      : short debounce length for simulation
//   clog2        : ceiling log2, used to size the debounce counters
//   edge_mode_e  : per-channel event edge selection
package pic_pkg;

  localparam int unsigned DEB_10MS_70M = 700000;
  localparam int unsigned DEB_SIM      = 4;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // BOTH overrides the RISE/FALL selection.
  function automatic edge_mode_e edge_mode(input logic rise, input logic both);
    if (both)      return EDGE_BOTH;
    else if (rise) return EDGE_RISE;
    else           return EDGE_FALL;
  endfunction

endpackage

// File: rtl/pic_debounce.sv
// One input channel: 2-flop synchroniser, debounce counter and the
// debounced LEVEL register.
//   i_clk   : PICCLK, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_din   : raw asynchronous input
//   o_level : debounced, synchronised level
module pic_debounce
  import pic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_SIM,
  parameter logic        IDLE       = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_din,
  output logic o_level
);

  localparam int unsigned    CW       = clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // A change is accepted only after DEB_CYCLES consecutive disagreeing
  // synchronised samples; any sample matching LEVEL restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= IDLE;
      r_sync  <= IDLE;
      r_level <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/pic_int_cond.sv
// Interrupt input conditioner upstream of the PIC16 INT pin.
// Per channel: synchronise + debounce (pic_debounce), edge detect,
// pending/overrun latching; a single registered INT for the core.
//   CLK   : PICCLK, rising edge
//   nRST  : asynchronous active-low reset
//   DIN   : raw asynchronous inputs
//   EN    : per-channel interrupt enable (masks INT only)
//   CLR   : per-channel clear of PEND/OVR, one cycle = one clear
//   LEVEL : debounced levels
//   PEND  : pending-event flags
//   OVR   : sticky overrun flags
//   INT   : registered interrupt request
module pic_int_cond
  import pic_pkg::*;
#(
  parameter int unsigned    N          = 4,
  parameter int unsigned    DEB_CYCLES = DEB_10MS_70M,
  parameter logic [N-1:0]   IDLE       = '0,
  parameter logic [N-1:0]   RISE       = '1,
  parameter logic [N-1:0]   BOTH       = '0
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [N-1:0] DIN,
  input  logic [N-1:0] EN,
  input  logic [N-1:0] CLR,
  output logic [N-1:0] LEVEL,
  output logic [N-1:0] PEND,
  output logic [N-1:0] OVR,
  output logic         INT
);

  logic [N-1:0] w_level;
  logic [N-1:0] w_evt;
  logic [N-1:0] r_level_q;
  logic [N-1:0] r_pend;
  logic [N-1:0] r_ovr;
  logic         r_int;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_ch
      localparam edge_mode_e MODE = edge_mode(RISE[g], BOTH[g]);

      pic_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .IDLE       (IDLE[g])
      ) u_deb (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_din   (DIN[g]),
        .o_level (w_level[g])
      );

      assign w_evt[g] = (MODE == EDGE_BOTH) ? (r_level_q[g] ^ w_level[g]) :
                        (MODE == EDGE_RISE) ? (~r_level_q[g] & w_level[g]) :
                                              (r_level_q[g] & ~w_level[g]);
    end
  endgenerate

  // Set wins over clear for PEND; clear wins for OVR.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_level_q <= IDLE;
      r_pend    <= '0;
      r_ovr     <= '0;
      r_int     <= 1'b0;
    end else begin
      r_level_q <= w_level;
      r_pend    <= w_evt | (r_pend & ~CLR);
      r_ovr     <= ~CLR & (r_ovr | (w_evt & r_pend));
      r_int     <= |(r_pend & EN);
    end
  end

  assign LEVEL = w_level;
  assign PEND  = r_pend;
  assign OVR   = r_ovr;
  assign INT   = r_int;

endmodule

// File: tb/tb_pic_int_cond.sv
// Self-checking bench for pic_int_cond: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_pic_int_cond;
  import pic_pkg::*;

  localparam int unsigned  N      = 4;
  localparam int unsigned  DEB    = DEB_SIM;
  localparam logic [N-1:0] IDLE_P = 4'b0000;
  localparam logic [N-1:0] RISE_P = 4'b1011;
  localparam logic [N-1:0] BOTH_P = 4'b1000;

  logic         CLK  = 1'b0;
  logic         nRST = 1'b0;
  logic [N-1:0] DIN  = IDLE_P;
  logic [N-1:0] EN   = '0;
  logic [N-1:0] CLR  = '0;
  logic [N-1:0] LEVEL, PEND, OVR;
  logic         INT;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  always #5 CLK = ~CLK;

  pic_int_cond #(
    .N          (N),
    .DEB_CYCLES (DEB),
    .IDLE       (IDLE_P),
    .RISE       (RISE_P),
    .BOTH       (BOTH_P)
  ) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .DIN   (DIN),
    .EN    (EN),
    .CLR   (CLR),
    .LEVEL (LEVEL),
    .PEND  (PEND),
    .OVR   (OVR),
    .INT   (INT)
  );

  // Behavioural model. m_hist[k] is DIN as sampled k+1 edges ago, so the
  // synchronised value seen before the current edge is m_hist[1]; a new
  // level is accepted when the last DEB synchronised samples all differ
  // from the current level.
  logic [N-1:0] m_hist [0:DEB];
  logic [N-1:0] m_lvl, m_lvl_q, m_pend, m_ovr;
  logic         m_int;

  always @(posedge CLK or negedge nRST) begin : mdl
    logic [N-1:0] ev, nl;
    bit rose, fell, stable;
    if (!nRST) begin
      for (int k = 0; k <= DEB; k++) m_hist[k] = IDLE_P;
      m_lvl   = IDLE_P;
      m_lvl_q = IDLE_P;
      m_pend  = '0;
      m_ovr   = '0;
      m_int   = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        rose  = !m_lvl_q[i] && m_lvl[i];
        fell  = m_lvl_q[i] && !m_lvl[i];
        ev[i] = BOTH_P[i] ? (rose || fell) : (RISE_P[i] ? rose : fell);
        stable = 1'b1;
        for (int m = 1; m <= DEB; m++) if (m_hist[m][i] == m_lvl[i]) stable = 1'b0;
        nl[i] = stable ? !m_lvl[i] : m_lvl[i];
      end
      m_int = |(m_pend & EN);
      for (int i = 0; i < N; i++) begin
        if (CLR[i]) begin
          m_ovr[i]  = 1'b0;
          m_pend[i] = ev[i];
        end else begin
          if (ev[i] && m_pend[i]) m_ovr[i] = 1'b1;
          if (ev[i]) m_pend[i] = 1'b1;
        end
      end
      m_lvl_q = m_lvl;
      m_lvl   = nl;
      for (int k = DEB; k >= 1; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = DIN;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      vectors++;
      if (LEVEL !== m_lvl) begin
        miscompares++;
        $display("FAIL level: got %b want %b at %0t", LEVEL, m_lvl, $time);
      end
      if (PEND !== m_pend) begin
        miscompares++;
        $display("FAIL pend: got %b want %b at %0t", PEND, m_pend, $time);
      end
      if (OVR !== m_ovr) begin
        miscompares++;
        $display("FAIL ovr: got %b want %b at %0t", OVR, m_ovr, $time);
      end
      if (INT !== m_int) begin
        miscompares++;
        $display("FAIL int: got %b want %b at %0t", INT, m_int, $time);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    nRST = 1'b0;
    tick(3);
    chk_on = 1'b1;
    nRST   = 1'b1;

    // 1: reset asserted while ch0 is mid-count, then released
    DIN[0] = 1'b1;
    tick(3);
    nRST = 1'b0;
    DIN  = '0;
    tick(2);
    nRST = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      expect_val("rst_level", 8'(LEVEL), 8'h0);
      expect_val("rst_pend",  8'(PEND),  8'h0);
      expect_val("rst_int",   8'(INT),   8'h0);
    end

    // 2: clean rising edge on ch0
    DIN[0] = 1'b1;
    EN     = 4'b0001;
    tick(5);
    expect_val("rise_level_early", 8'(LEVEL[0]), 8'h0);
    tick(1);
    expect_val("rise_level", 8'(LEVEL[0]), 8'h1);
    expect_val("rise_pend_early", 8'(PEND[0]), 8'h0);
    tick(1);
    expect_val("rise_pend", 8'(PEND[0]), 8'h1);
    expect_val("rise_int_early", 8'(INT), 8'h0);
    tick(1);
    expect_val("rise_int", 8'(INT), 8'h1);
    CLR[0] = 1'b1;
    tick(1);
    CLR = '0;
    expect_val("clr_pend", 8'(PEND[0]), 8'h0);
    expect_val("clr_int_lag", 8'(INT), 8'h1);
    tick(1);
    expect_val("clr_int", 8'(INT), 8'h0);

    // 3: bounce rejection on ch1
    for (int k = 0; k < 4; k++) begin
      DIN[1] = (k % 2 == 0);
      tick(2);
    end
    DIN[1] = 1'b1;
    tick(5);
    expect_val("bounce_level_early", 8'(LEVEL[1]), 8'h0);
    expect_val("bounce_pend_early", 8'(PEND[1]), 8'h0);
    tick(1);
    expect_val("bounce_level", 8'(LEVEL[1]), 8'h1);
    tick(1);
    expect_val("bounce_pend", 8'(PEND[1]), 8'h1);

    // 4: falling-only ch2, both-edge ch3
    DIN[3:2] = 2'b11;
    tick(10);
    expect_val("fall_ch_on_rise", 8'(PEND[2]), 8'h0);
    expect_val("both_ch_on_rise", 8'(PEND[3]), 8'h1);
    CLR = 4'b1000;
    tick(1);
    CLR = '0;
    expect_val("both_ch_cleared", 8'(PEND[3]), 8'h0);
    DIN[3:2] = 2'b00;
    tick(10);
    expect_val("fall_ch_on_fall", 8'(PEND[2]), 8'h1);
    expect_val("both_ch_on_fall", 8'(PEND[3]), 8'h1);

    // 5: overrun, then set/clear collision on ch0
    CLR = '1;
    tick(1);
    CLR = '0;
    DIN[0] = 1'b0;
    tick(10);
    expect_val("ovr_fall_no_evt", 8'(PEND[0]), 8'h0);
    DIN[0] = 1'b1;
    tick(10);
    expect_val("ovr_first_pend", 8'(PEND[0]), 8'h1);
    expect_val("ovr_first_ovr", 8'(OVR[0]), 8'h0);
    DIN[0] = 1'b0;
    tick(10);
    DIN[0] = 1'b1;
    tick(10);
    expect_val("ovr_set", 8'(OVR[0]), 8'h1);
    DIN[0] = 1'b0;
    tick(10);
    DIN[0] = 1'b1;
    tick(6);
    CLR[0] = 1'b1;
    tick(1);
    CLR = '0;
    expect_val("collide_pend", 8'(PEND[0]), 8'h1);
    expect_val("collide_ovr", 8'(OVR[0]), 8'h0);

    // 6: masking with events on all channels
    EN  = '0;
    CLR = '1;
    tick(1);
    CLR = '0;
    DIN = 4'b0100;
    tick(10);
    CLR = '1;
    tick(1);
    CLR = '0;
    DIN = 4'b1011;
    tick(10);
    expect_val("mask_pend", 8'(PEND), 8'h0f);
    expect_val("mask_int", 8'(INT), 8'h0);
    EN = 4'b0100;
    tick(1);
    expect_val("unmask_int", 8'(INT), 8'h1);

    // Randomized phase, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) DIN[$urandom_range(N-1)] ^= 1'b1;
      if ($urandom_range(15) == 0) EN = N'($urandom);
      CLR = ($urandom_range(5) == 0) ? N'($urandom) : '0;
      if ($urandom_range(499) == 0) begin
        nRST = 1'b0;
        tick(2);
        nRST = 1'b1;
      end
      tick(1);
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
